// File: rtl/i2c_eeprom_slave.sv
// I2C target modelling a 2 Kbyte serial EEPROM (device code 1010, 11-bit word address).
// Build option EEPROM_WP_EN adds the WP pin: while high, data bytes are NACKed and not stored.
//
// state        | meaning
// S_IDLE       | bus free, waiting for START
// S_DEV        | shifting in control byte
// S_ACK_DEV    | ACK slot after control byte
// S_ADDR       | shifting in word address A7:A0
// S_ACK_ADDR   | ACK slot after address byte
// S_WDATA      | shifting in write data
// S_ACK_WDATA  | ACK (or WP NACK) slot after data byte
// S_RDATA      | shifting out read data
// S_MACK       | master ACK/NACK slot after read byte
// S_WAIT_START | not addressed / NACKed, ignore bits until START or STOP
module i2c_eeprom_slave #(
   parameter int         MEM_DEPTH = 2048,
   parameter logic [3:0] DEV_CODE  = 4'b1010
) (
   input  logic CLK,
   input  logic RESET,
   input  logic SCL,
   inout  wire  SDA,
`ifdef EEPROM_WP_EN
   input  logic WP,
`endif
   output logic BUSY
);
   typedef enum logic [3:0] {
      S_IDLE, S_DEV, S_ACK_DEV, S_ADDR, S_ACK_ADDR,
      S_WDATA, S_ACK_WDATA, S_RDATA, S_MACK, S_WAIT_START
   } state_t;

   state_t      state_q;
   logic [1:0]  scl_sync_q, sda_sync_q;
   logic        scl_prev_q, sda_prev_q;
   logic [10:0] ptr_q;
   logic [2:0]  a_hi_q;
   logic [3:0]  bit_cnt_q;
   logic [7:0]  shift_q;
   logic        sda_oe_q, busy_q, rw_q, nack_q;
   logic [7:0]  mem_q [MEM_DEPTH];

   logic        scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
   logic [7:0]  rx_byte, rd_byte;
   logic [10:0] ptr_inc_d;
   logic        wr_block, mem_we;

`ifdef EEPROM_WP_EN
   logic wp_q;
   always_ff @(posedge CLK) begin
      if (RESET) wp_q <= 1'b0;
      else       wp_q <= WP;
   end
   assign wr_block = wp_q;
`else
   assign wr_block = 1'b0;
`endif

   // Synchronizers reset to the idle-bus level so reset release never fakes a START.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[0], SCL};
         sda_sync_q <= {sda_sync_q[0], SDA};
         scl_prev_q <= scl_sync_q[1];
         sda_prev_q <= sda_sync_q[1];
      end
   end

   assign scl_s     = scl_sync_q[1];
   assign sda_s     = sda_sync_q[1];
   assign scl_rise  = scl_s & ~scl_prev_q;
   assign scl_fall  = ~scl_s & scl_prev_q;
   assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
   assign rx_byte   = {shift_q[6:0], sda_s};
   assign rd_byte   = mem_q[ptr_q];
   assign ptr_inc_d = (ptr_q == 11'(MEM_DEPTH - 1)) ? 11'd0 : ptr_q + 11'd1;
   assign mem_we    = !RESET && !start_det && !stop_det && (state_q == S_WDATA)
                      && scl_rise && (bit_cnt_q == 4'd7) && !wr_block;

   always_ff @(posedge CLK) begin
      if (mem_we) mem_q[ptr_q] <= rx_byte;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         a_hi_q    <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         sda_oe_q  <= 1'b0;
         busy_q    <= 1'b0;
         rw_q      <= 1'b0;
         nack_q    <= 1'b0;
      end else if (start_det) begin
         state_q   <= S_DEV;
         bit_cnt_q <= '0;
         sda_oe_q  <= 1'b0;
         busy_q    <= 1'b1;
      end else if (stop_det) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         sda_oe_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            S_DEV, S_ADDR, S_WDATA: begin
               if (scl_rise) begin
                  shift_q   <= rx_byte;
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     bit_cnt_q <= 4'd8;
                     nack_q    <= 1'b0;
                     if (state_q == S_DEV) begin
                        if (rx_byte[7:4] != DEV_CODE) begin
                           state_q <= S_WAIT_START;
                        end else begin
                           state_q <= S_ACK_DEV;
                           rw_q    <= rx_byte[0];
                           if (!rx_byte[0]) a_hi_q <= rx_byte[3:1];
                        end
                     end else if (state_q == S_ADDR) begin
                        ptr_q   <= {a_hi_q, rx_byte};
                        state_q <= S_ACK_ADDR;
                     end else begin
                        if (!wr_block) ptr_q <= ptr_inc_d;
                        nack_q  <= wr_block;
                        state_q <= S_ACK_WDATA;
                     end
                  end
               end
            end
            // bit_cnt 8 = waiting for the fall that opens the slot, 9 = slot open
            S_ACK_DEV, S_ACK_ADDR, S_ACK_WDATA: begin
               if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     sda_oe_q  <= ~nack_q;
                     bit_cnt_q <= 4'd9;
                  end else begin
                     sda_oe_q  <= 1'b0;
                     bit_cnt_q <= '0;
                     if (state_q == S_ACK_DEV && rw_q) begin
                        state_q  <= S_RDATA;
                        shift_q  <= rd_byte;
                        sda_oe_q <= ~rd_byte[7];
                     end else if (state_q == S_ACK_DEV) begin
                        state_q <= S_ADDR;
                     end else begin
                        state_q <= S_WDATA;
                     end
                  end
               end
            end
            S_RDATA: begin
               if (scl_rise) begin
                  shift_q   <= {shift_q[6:0], 1'b0};
                  bit_cnt_q <= bit_cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     sda_oe_q  <= 1'b0;
                     state_q   <= S_MACK;
                     ptr_q     <= ptr_inc_d;
                     bit_cnt_q <= '0;
                  end else begin
                     sda_oe_q <= ~shift_q[7];
                  end
               end
            end
            S_MACK: begin
               if (scl_rise) begin
                  if (sda_s) begin
                     state_q <= S_WAIT_START;
                  end else begin
                     state_q   <= S_RDATA;
                     shift_q   <= rd_byte;
                     bit_cnt_q <= '0;
                  end
               end
            end
            S_IDLE, S_WAIT_START: ;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign SDA  = sda_oe_q ? 1'b0 : 1'bz;
   assign BUSY = busy_q;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bench for i2c_eeprom_slave: bit-banged I2C master, reference memory model and
// a scoreboard that pairs expected ACK/read bytes with what the master observes.
`timescale 1ns/1ps
module tb_i2c_eeprom_slave;
   localparam int Q = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic scl = 1'b1;
   logic sda_low = 1'b0;
   logic busy;
   wire  sda_w;

   always #5 clk = ~clk;
   assign sda_w = sda_low ? 1'b0 : 1'bz;
   pullup (sda_w);

`ifdef EEPROM_WP_EN
   logic wp = 1'b0;
`endif

   i2c_eeprom_slave dut (
      .CLK   (clk),
      .RESET (rst),
      .SCL   (scl),
      .SDA   (sda_w),
`ifdef EEPROM_WP_EN
      .WP    (wp),
`endif
      .BUSY  (busy)
   );

   string      exp_tag_q[$];
   logic [7:0] exp_val_q[$];
   logic [7:0] obs_q[$];
   logic [7:0] wbuf[$];
   int         wr_addrs[$];
   int         total = 0;
   int         bad = 0;

   logic [7:0] ref_mem [2048];
   bit         ref_valid [2048];
   int         ref_ptr = 0;
   bit         ref_wp = 1'b0;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %02h expected %02h", nm, act, want);
      end
   endtask

   function automatic void expect_v(input string tag, input logic [7:0] v);
      exp_tag_q.push_back(tag);
      exp_val_q.push_back(v);
   endfunction

   // monitor: pairs every observed slave response with the oldest expectation
   initial begin
      forever begin
         @(posedge clk);
         while (obs_q.size() > 0) begin
            logic [7:0] o;
            o = obs_q.pop_front();
            if (exp_val_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_obs: got %02h expected nothing", o);
            end else begin
               chk(exp_tag_q.pop_front(), o, exp_val_q.pop_front());
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_xfer(input bit b, output logic got);
      sda_low = !b; wait_clk(Q);
      scl = 1'b1;   wait_clk(Q);
      got = sda_w;  wait_clk(Q);
      scl = 1'b0;   wait_clk(Q);
   endtask

   task automatic i2c_start();
      sda_low = 1'b0; wait_clk(Q);
      scl = 1'b1;     wait_clk(Q);
      sda_low = 1'b1; wait_clk(Q);
      scl = 1'b0;     wait_clk(Q);
   endtask

   task automatic i2c_stop();
      sda_low = 1'b1; wait_clk(Q);
      scl = 1'b1;     wait_clk(Q);
      sda_low = 1'b0; wait_clk(Q);
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic g;
      for (int i = 7; i >= 0; i--) bit_xfer(b[i], g);
      bit_xfer(1'b1, g);
      obs_q.push_back({7'd0, g});
   endtask

   task automatic recv_byte(input bit nack);
      logic       g;
      logic [7:0] d;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, g);
         d[i] = g;
      end
      bit_xfer(nack, g);
      obs_q.push_back(d);
   endtask

   function automatic logic [7:0] ctrl_w(input int addr);
      return {4'b1010, 3'((addr >> 8) & 7), 1'b0};
   endfunction

   function automatic void expect_reads(input int n);
      for (int i = 0; i < n; i++) begin
         expect_v("rd_data", ref_mem[ref_ptr]);
         ref_ptr = (ref_ptr + 1) % 2048;
      end
   endfunction

   task automatic write_txn(input int addr);
      int a;
      expect_v("ack_ctrl_w", 8'd0);
      expect_v("ack_addr", 8'd0);
      a = addr;
      foreach (wbuf[i]) begin
         if (ref_wp) begin
            expect_v("nack_wp", 8'd1);
         end else begin
            expect_v("ack_data", 8'd0);
            ref_mem[a] = wbuf[i];
            ref_valid[a] = 1'b1;
            wr_addrs.push_back(a);
            a = (a + 1) % 2048;
         end
      end
      ref_ptr = a;
      i2c_start();
      send_byte(ctrl_w(addr));
      send_byte(8'(addr));
      foreach (wbuf[i]) send_byte(wbuf[i]);
      i2c_stop();
   endtask

   task automatic random_read(input int addr, input int n);
      expect_v("ack_ctrl_w", 8'd0);
      expect_v("ack_addr", 8'd0);
      expect_v("ack_ctrl_r", 8'd0);
      ref_ptr = addr;
      expect_reads(n);
      i2c_start();
      send_byte(ctrl_w(addr));
      send_byte(8'(addr));
      i2c_start();
      send_byte({4'b1010, 3'($urandom), 1'b1});
      for (int i = 0; i < n; i++) recv_byte(i == n - 1);
      i2c_stop();
   endtask

   task automatic cur_read(input int n);
      expect_v("ack_ctrl_r", 8'd0);
      expect_reads(n);
      i2c_start();
      send_byte(8'hA1);
      for (int i = 0; i < n; i++) recv_byte(i == n - 1);
      i2c_stop();
   endtask

   initial begin
      int a, n, op;
      wait_clk(5);
      chk("reset_busy", {7'd0, busy}, 8'd0);
      chk("reset_sda", {7'd0, sda_w}, 8'd1);
      rst = 1'b0;
      wait_clk(Q);

      wbuf.delete(); wbuf.push_back(8'h6C); write_txn('h3A8);
      wbuf.delete(); wbuf.push_back(8'h5A); write_txn('h3A7);
      random_read('h3A7, 1);
      cur_read(1);

      wbuf.delete(); wbuf.push_back(8'h11); wbuf.push_back(8'h22); write_txn('h7FF);
      random_read('h7FF, 2);

      expect_v("nack_bad_dev", 8'd1);
      expect_v("ignored_byte", 8'd1);
      expect_v("ignored_byte", 8'd1);
      i2c_start();
      send_byte(8'h90);
      send_byte(8'h00);
      send_byte(8'h33);
      i2c_stop();
      random_read('h000, 1);

      // STOP after 4 data bits: byte discarded, ptr stays at the address
      begin
         logic g;
         expect_v("ack_ctrl_w", 8'd0);
         expect_v("ack_addr", 8'd0);
         ref_ptr = 'h3A7;
         i2c_start();
         send_byte(ctrl_w('h3A7));
         send_byte(8'hA7);
         for (int i = 7; i >= 4; i--) bit_xfer(i[0], g);
         chk("busy_mid_byte", {7'd0, busy}, 8'd1);
         sda_low = 1'b1; wait_clk(Q);
         scl = 1'b1;     wait_clk(Q);
         sda_low = 1'b0; wait_clk(3);
         chk("busy_after_stop", {7'd0, busy}, 8'd0);
         wait_clk(Q);
      end
      cur_read(1);

      // RESET while the slave is driving a 0 data bit
      expect_v("ack_ctrl_r", 8'd0);
      i2c_start();
      send_byte(8'hA1);
      chk("sda_rdata_bit7", {7'd0, sda_w}, {7'd0, ref_mem[ref_ptr][7]});
      rst = 1'b1;
      wait_clk(1);
      chk("sda_after_reset", {7'd0, sda_w}, 8'd1);
      chk("busy_after_reset", {7'd0, busy}, 8'd0);
      wait_clk(2);
      rst = 1'b0;
      scl = 1'b1;
      wait_clk(Q);
      ref_ptr = 0;
      cur_read(1);

      for (int k = 0; k < 12; k++) begin
         op = $urandom_range(0, 2);
         if (op == 0) begin
            a = $urandom_range(0, 2047);
            n = $urandom_range(1, 4);
            wbuf.delete();
            for (int i = 0; i < n; i++) wbuf.push_back(8'($urandom_range(0, 255)));
            write_txn(a);
         end else if (op == 2 && ref_valid[ref_ptr]) begin
            cur_read(1);
         end else begin
            a = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
            n = 1;
            while (n < 3 && ref_valid[(a + n) % 2048]) n++;
            random_read(a, n);
         end
      end

`ifdef EEPROM_WP_EN
      wbuf.delete(); wbuf.push_back(8'h3C); write_txn('h010);
      wp = 1'b1; ref_wp = 1'b1;
      wait_clk(4);
      wbuf.delete(); wbuf.push_back(8'hFF); write_txn('h010);
      random_read('h010, 1);
      wp = 1'b0; ref_wp = 1'b0;
`endif

      wait_clk(20);
      chk("scoreboard_drain", 8'(exp_val_q.size()), 8'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2c_eeprom_slave.md
# i2c_eeprom_slave

Synthesizable I2C responder modelling a 2 Kbyte serial EEPROM with an 11-bit word address: device code 1010, A10:A8 carried in the control byte, A7:A0 in the address byte. It is the target end of the EEPROM write/read master on the same SCL/SDA pair. It serves as the bench/FPGA partner for that master: it detects START/STOP, ACKs, stores written bytes and shifts read bytes back. It samples SCL/SDA with its own faster system clock.

## Interface
- MEM_DEPTH, 2048, bytes of storage; address pointer width 11, wraps modulo MEM_DEPTH
- DEV_CODE, 4'b1010, control-byte bits [7:4] the block answers to
- CLK  input  1  system clock; frequency ≥ 8× SCL frequency
- RESET  input  1  synchronous, active-high; reset RESET, synchronous, active-high; clock CLK
- SCL  input  1  serial clock from master
- SDA  inout  1  serial data; block only drives 0 or releases (1'bz); external pull-up
- WP  input  1  write protect (present only with EEPROM_WP_EN)
- BUSY  output  1  high from START detect to STOP/abort return to IDLE

## Operation
- SCL and SDA pass through 2-flop synchronizers; edges come from synced-now vs synced-previous.
- START: synced SDA falls while synced SCL high. It enters DEV from any state, including repeated START, and clears the bit counter.
- STOP: synced SDA rises while synced SCL high. It enters IDLE from any state, releases SDA and clears BUSY.
- Data bits are sampled on synced SCL rising edges, MSB first. SDA may only change in the cycle after a synced SCL falling edge.
- States: IDLE, DEV, ACK_DEV, ADDR, ACK_ADDR, WDATA, ACK_WDATA, RDATA, MACK, WAIT_START.
- DEV transitions after 8 bits:
  - If [7:4] ≠ DEV_CODE, go to WAIT_START without ACK.
  - If [7:4] matches, go to ACK_DEV.
  - For a write (R/W=0), latch A10:A8 from [3:1]. For a read, ignore [3:1].
- ACK_DEV: pull SDA low from the falling edge after bit 8 to the falling edge after bit 9. It then goes to ADDR on a write, or to RDATA on a read, loading mem[ptr] into the shift register.
- ADDR: after 8 bits, set ptr = {A10:A8, byte}, then ACK_ADDR (ACK) → WDATA.
- WDATA: after 8 bits, write mem[ptr] in the cycle of the 8th rising sample, ptr ← ptr+1, then ACK_WDATA → WDATA for further bytes. Unlimited sequential write, no page boundary.
- RDATA: drive bit 7 after the falling edge that ends the ACK. A 1 bit is released, never driven high.
- RDATA after 8 bits: release SDA, go to MACK, ptr ← ptr+1.
- MACK, sampled on the 9th rising edge:
  - SDA=0: load mem[ptr], go to RDATA.
  - SDA=1 (NACK): go to WAIT_START.
- Random read is ctrl-W, addr, repeated START, ctrl-R. Current-address read is ctrl-R directly, using the retained ptr.
- WAIT_START ignores everything except START/STOP.
- Memory contents are not reset. ptr resets to 0.

## Timing
- Reset values: SDA released (z), BUSY=0, state IDLE, ptr=0, bit counter 0, shift register 0.
- START/STOP detect latency: 3 CLK after the pin edge (2 sync + 1 edge register).
- ACK/data drive: SDA updated 1 CLK after the synced SCL falling edge is detected (≤4 CLK after the pin edge).
- SDA release at end of ACK or read bit: same 4-CLK bound.
- START and a data edge in the same cycle: START wins.
- STOP during ADDR or mid-WDATA: partial byte discarded, memory unchanged.
- ptr 0x7FF + 1 = 0x000 for both read and write.
- RESET mid-transfer: SDA released the next cycle. The next transaction needs a fresh START.

## Configuration
- EEPROM_WP_EN defined:
  - WP port exists.
  - While WP=1, WDATA bytes are NACKed (SDA released in the ACK slot), the memory write is suppressed and ptr is not incremented.
  - Device and address bytes are still ACKed.
  - Reads are unaffected.
- EEPROM_WP_EN undefined: no WP port; writes are always enabled.

## Test plan
- Byte write: START, 0xA6, 0xA7, 0x5A, STOP → three ACKs (SDA=0 in each 9th bit) and mem[0x3A7]=0x5A.
- Random read: START, 0xA6, 0xA7, Sr, 0xA1, read 1 byte, NACK, STOP → 0x5A on SDA and ptr=0x3A8.
- Sequential read wrap: preload mem[0x7FF]=0x11 and mem[0x000]=0x22; set ptr 0x7FF; read 2 bytes with ACK then NACK → 0x11, 0x22.
- Wrong device code: START, 0x90 → SDA stays z in the ACK slot, and later bytes until STOP are ignored with no memory change.
- Abort and reset:
  - STOP after 4 bits of the data byte → mem at the target is unchanged and BUSY=0 within 3 CLK.
  - RESET asserted during RDATA → SDA z next cycle.
- EEPROM_WP_EN with WP=1: byte write of 0xFF to 0x010 → data slot NACKed and mem[0x010] unchanged.
